// File: rtl/hamming_pkg.sv
// Shared Hamming SEC-DED helpers. Functions work on maximum-size vectors and
// take the parity-bit count r, so one package serves every legal code size.
package hamming_pkg;

  localparam int RMAX = 6;
  localparam int NMAX = 1 << RMAX;
  localparam int KMAX = NMAX - RMAX - 1;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  function automatic logic is_parity_pos(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Codeword position carrying data bit idx (data fills non-power-of-two slots).
  function automatic int data_pos(input int r, input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p < NMAX; p++) begin
      if ((p < (1 << r)) && !is_parity_pos(p)) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [NMAX-1:0] encode(input int r, input logic [KMAX-1:0] data);
    logic [NMAX-1:0] cw;
    logic            par;
    int              idx;
    cw  = '0;
    idx = 0;
    for (int p = 1; p < NMAX; p++) begin
      if ((p < (1 << r)) && !is_parity_pos(p)) begin
        cw[p] = data[idx];
        idx++;
      end
    end
    for (int j = 0; j < RMAX; j++) begin
      if (j < r) begin
        par = 1'b0;
        for (int p = 1; p < NMAX; p++) begin
          if ((p < (1 << r)) && (((p >> j) & 1) == 1) && (p != (1 << j))) par ^= cw[p];
        end
        cw[1 << j] = par;
      end
    end
    // Position 0 is still zero here, so this is the parity of positions 1..N-1.
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [RMAX-1:0] syndrome(input int r, input logic [NMAX-1:0] cw);
    logic [RMAX-1:0] s;
    s = '0;
    for (int p = 1; p < NMAX; p++) begin
      if ((p < (1 << r)) && cw[p]) s = s ^ RMAX'(p);
    end
    return s;
  endfunction

  function automatic logic overall_parity(input int r, input logic [NMAX-1:0] cw);
    logic q;
    q = 1'b0;
    for (int p = 0; p < NMAX; p++) begin
      if (p < (1 << r)) q ^= cw[p];
    end
    return q;
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SEC-DED decoder: syndrome, overall parity, single-bit fix and
// data extraction for one full frame.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int R = 3,
  localparam int N = 1 << R,
  localparam int K = N - R - 1
) (
  input  logic [N-1:0] frame,
  output logic [K-1:0] data,
  output logic [R-1:0] syn,
  output logic         corr,
  output logic         uncorr
);

  logic [NMAX-1:0] frame_ext;
  logic            q;
  logic [N-1:0]    fixed;

  always_comb begin
    frame_ext          = '0;
    frame_ext[N-1:0]   = frame;
    syn                = R'(syndrome(R, frame_ext));
    q                  = overall_parity(R, frame_ext);
  end

  // Odd parity means one flipped bit; s=0 then points at position 0, which carries no data.
  assign corr   = q;
  assign uncorr = !q && (syn != '0);

  always_comb begin
    fixed = frame;
    if (q && (syn != '0)) fixed[syn] = ~frame[syn];
  end

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_data
      localparam int P = data_pos(R, gi);
      assign data[gi] = fixed[P];
    end
  endgenerate

endmodule

// File: rtl/hamming_secded_link.sv
// Hamming SEC-DED serial link: TX encode+serialise FSM, RX frame collector,
// registered decode outputs and saturating error counters.
module hamming_secded_link
  import hamming_pkg::*;
#(
  parameter  int R  = 3,
  parameter  int CW = 16,
  localparam int N  = 1 << R,
  localparam int K  = N - R - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [K-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          tx_bit,
  output logic          tx_valid,
  output logic          tx_sof,
  input  logic          rx_bit,
  input  logic          rx_valid,
  input  logic          rx_sof,
  output logic [K-1:0]  out_data,
  output logic          out_valid,
  output logic          out_corr,
  output logic          out_uncorr,
  output logic [R-1:0]  err_pos,
  output logic [CW-1:0] corr_cnt,
  output logic [CW-1:0] uncorr_cnt
);

  localparam logic [R-1:0]  LAST_POS = '1;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  tx_state_e       state_q, state_d;
  logic [R-1:0]    tx_pos_q, tx_pos_d;
  logic [N-1:0]    tx_cw_q, tx_cw_d;
  logic [N-1:0]    enc_cw;
  logic [KMAX-1:0] data_ext;
  logic            tx_last;

  always_comb begin
    data_ext        = '0;
    data_ext[K-1:0] = in_data;
    enc_cw          = N'(encode(R, data_ext));
  end

  assign tx_last  = (state_q == TX_SHIFT) && (tx_pos_q == LAST_POS);
  assign in_ready = (state_q == TX_IDLE) || tx_last;
  assign tx_valid = (state_q == TX_SHIFT);
  assign tx_sof   = tx_valid && (tx_pos_q == '0);
  assign tx_bit   = tx_valid && tx_cw_q[tx_pos_q];

  always_comb begin
    state_d  = state_q;
    tx_pos_d = tx_pos_q;
    tx_cw_d  = tx_cw_q;
    case (state_q)
      TX_IDLE: begin
        if (in_valid) begin
          state_d  = TX_SHIFT;
          tx_pos_d = '0;
          tx_cw_d  = enc_cw;
        end
      end
      TX_SHIFT: begin
        if (tx_last) begin
          // A word taken on the last bit restarts at position 0 with no gap.
          if (in_valid) begin
            tx_pos_d = '0;
            tx_cw_d  = enc_cw;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          tx_pos_d = tx_pos_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      tx_pos_q <= '0;
      tx_cw_q  <= '0;
    end else begin
      state_q  <= state_d;
      tx_pos_q <= tx_pos_d;
      tx_cw_q  <= tx_cw_d;
    end
  end

  logic         rx_open_q, rx_open_d;
  logic [R-1:0] rx_pos_q, rx_pos_d;
  logic [N-1:0] rx_buf_q, rx_buf_d;
  logic         rx_done;

  always_comb begin
    rx_open_d = rx_open_q;
    rx_pos_d  = rx_pos_q;
    rx_buf_d  = rx_buf_q;
    rx_done   = 1'b0;
    if (rx_valid) begin
      if (rx_sof) begin
        rx_buf_d    = '0;
        rx_buf_d[0] = rx_bit;
        rx_pos_d    = R'(1);
        rx_open_d   = 1'b1;
      end else if (rx_open_q) begin
        rx_buf_d[rx_pos_q] = rx_bit;
        rx_pos_d           = rx_pos_q + 1'b1;
        if (rx_pos_q == LAST_POS) begin
          rx_open_d = 1'b0;
          rx_done   = 1'b1;
        end
      end
    end
  end

  logic [K-1:0] dec_data;
  logic [R-1:0] dec_syn;
  logic         dec_corr, dec_uncorr;

  // Decoder sees the buffer including the bit arriving this cycle.
  hamming_secded_dec #(.R(R)) u_dec (
    .frame  (rx_buf_d),
    .data   (dec_data),
    .syn    (dec_syn),
    .corr   (dec_corr),
    .uncorr (dec_uncorr)
  );

  logic [K-1:0]  out_data_q;
  logic          out_valid_q, out_corr_q, out_uncorr_q;
  logic [R-1:0]  err_pos_q;
  logic [CW-1:0] corr_cnt_q, uncorr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_open_q    <= 1'b0;
      rx_pos_q     <= '0;
      rx_buf_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      err_pos_q    <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      rx_open_q   <= rx_open_d;
      rx_pos_q    <= rx_pos_d;
      rx_buf_q    <= rx_buf_d;
      out_valid_q <= rx_done;
      if (rx_done) begin
        out_data_q   <= dec_data;
        out_corr_q   <= dec_corr;
        out_uncorr_q <= dec_uncorr;
        err_pos_q    <= dec_syn;
      end
      if (out_valid_q && out_corr_q && (corr_cnt_q != CNT_MAX))
        corr_cnt_q <= corr_cnt_q + 1'b1;
      if (out_valid_q && out_uncorr_q && (uncorr_cnt_q != CNT_MAX))
        uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;
  assign err_pos    = err_pos_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_link.sv
// Self-checking bench for hamming_secded_link (R=3): loopback with bit-flip
// masks, hand-driven RX frames, reset abort and counter saturation.
module tb_hamming_secded_link;

  localparam int R    = 3;
  localparam int CW   = 3;
  localparam int N    = 8;
  localparam int K    = 4;
  localparam int CMAX = 7;

  typedef struct packed {
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
    logic [2:0] s;
  } dec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [K-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx_bit, tx_valid, tx_sof;
  logic          rx_bit, rx_valid, rx_sof;
  logic [K-1:0]  out_data;
  logic          out_valid, out_corr, out_uncorr;
  logic [R-1:0]  err_pos;
  logic [CW-1:0] corr_cnt, uncorr_cnt;

  logic man_mode = 1'b0;
  logic m_bit = 1'b0, m_valid = 1'b0, m_sof = 1'b0;
  logic lb_bit = 1'b0, lb_valid = 1'b0, lb_sof = 1'b0;

  assign rx_bit   = man_mode ? m_bit   : lb_bit;
  assign rx_valid = man_mode ? m_valid : lb_valid;
  assign rx_sof   = man_mode ? m_sof   : lb_sof;

  always #5 clk = ~clk;

  hamming_secded_link #(.R(R), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .tx_sof     (tx_sof),
    .rx_bit     (rx_bit),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr),
    .err_pos    (err_pos),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: data in slots 3,5,6,7, even-parity groups, then overall parity.
  function automatic logic [7:0] model_enc(input logic [3:0] d);
    logic [7:0] cw;
    logic       par;
    cw = '0;
    cw[3] = d[0];
    cw[5] = d[1];
    cw[6] = d[2];
    cw[7] = d[3];
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int p = 1; p < 8; p++)
        if ((((p >> j) & 1) == 1) && (p != (1 << j))) par ^= cw[p];
      cw[1 << j] = par;
    end
    cw[0] = ^cw[7:1];
    return cw;
  endfunction

  function automatic dec_t model_dec(input logic [7:0] f);
    dec_t       r;
    int         s;
    int         q;
    logic [7:0] g;
    s = 0;
    q = 0;
    for (int p = 0; p < 8; p++)
      if (f[p]) begin
        s = s ^ p;
        q = q ^ 1;
      end
    g = f;
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    if (q == 1) begin
      r.corr = 1'b1;
      if (s != 0) g[s] = ~g[s];
    end else if (s != 0) begin
      r.uncorr = 1'b1;
    end
    r.data = {g[7], g[6], g[5], g[3]};
    r.s    = 3'(s);
    return r;
  endfunction

  function automatic dec_t mk_dec(input logic [3:0] d, input logic c, input logic u, input logic [2:0] s);
    dec_t r;
    r.data   = d;
    r.corr   = c;
    r.uncorr = u;
    r.s      = s;
    return r;
  endfunction

  logic [7:0] txq[$];
  logic [7:0] maskq[$];
  dec_t       expq[$];
  int         cyc = 0;
  int         exp_ov_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // TX monitor: checks the serial stream and drives the loopback with the frame's flip mask.
  int         ti = 0;
  int         run_len = 0;
  int         last_run = 0;
  logic [7:0] cw_c, m_c;

  always @(negedge clk) begin
    if (rst) begin
      ti = 0;
      txq.delete();
      maskq.delete();
      lb_valid = 1'b0;
      lb_sof   = 1'b0;
      lb_bit   = 1'b0;
      run_len  = 0;
    end else if (tx_valid) begin
      run_len++;
      check("in_ready_shift", in_ready, (ti == N - 1));
      if (txq.size() == 0) begin
        check("tx_unexpected", tx_valid, 0);
        lb_valid = 1'b0;
      end else begin
        cw_c = txq[0];
        m_c  = maskq[0];
        check("tx_sof", tx_sof, (ti == 0));
        check("tx_bit", tx_bit, cw_c[ti]);
        lb_bit   = tx_bit ^ m_c[ti];
        lb_sof   = tx_sof;
        lb_valid = 1'b1;
        if (ti == N - 1) begin
          exp_ov_cyc = cyc + 1;
          void'(txq.pop_front());
          void'(maskq.pop_front());
          ti = 0;
        end else begin
          ti++;
        end
      end
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len  = 0;
      lb_valid = 1'b0;
      lb_sof   = 1'b0;
      lb_bit   = 1'b0;
      check("in_ready_idle", in_ready, 1);
    end
  end

  // RX monitor: decoded outputs against the scoreboard, counters one cycle later.
  int   ccnt = 0;
  int   ucnt = 0;
  logic pend = 1'b0;
  dec_t ex;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      ccnt = 0;
      ucnt = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("corr_cnt", corr_cnt, ccnt);
        check("uncorr_cnt", uncorr_cnt, ucnt);
        pend = 1'b0;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("rx_unexpected", out_valid, 0);
        end else begin
          ex = expq.pop_front();
          check("rx_latency", cyc, exp_ov_cyc);
          check("out_data", out_data, ex.data);
          check("out_corr", out_corr, ex.corr);
          check("out_uncorr", out_uncorr, ex.uncorr);
          check("err_pos", err_pos, ex.s);
          if (ex.corr && ccnt < CMAX) ccnt++;
          if (ex.uncorr && ucnt < CMAX) ucnt++;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [3:0] w, input logic [7:0] m, input logic [7:0] cw_exp, input dec_t e);
    int g;
    g = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("accept_wait", in_ready, 1);
    txq.push_back(cw_exp);
    maskq.push_back(m);
    expq.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("tx_start", {tx_valid, tx_sof}, 2'b11);
  endtask

  task automatic send_rand(input logic [3:0] w, input logic [7:0] m);
    send(w, m, model_enc(w), model_dec(model_enc(w) ^ m));
  endtask

  task automatic drive_rx(input logic b, input logic v, input logic s);
    @(negedge clk);
    m_bit   = b;
    m_valid = v;
    m_sof   = s;
  endtask

  task automatic rx_frame(input logic [7:0] f);
    expq.push_back(model_dec(f));
    for (int i = 0; i < 8; i++) begin
      drive_rx(f[i], 1'b1, (i == 0));
      if (i == 7) exp_ov_cyc = cyc + 1;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((txq.size() != 0 || expq.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain", (txq.size() == 0 && expq.size() == 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_in_ready"}, in_ready, 1);
    check({pfx, "_tx"}, {tx_bit, tx_valid, tx_sof}, 3'b000);
    check({pfx, "_out_flags"}, {out_valid, out_corr, out_uncorr}, 3'b000);
    check({pfx, "_out_data"}, out_data, 0);
    check({pfx, "_err_pos"}, err_pos, 0);
    check({pfx, "_corr_cnt"}, corr_cnt, 0);
    check({pfx, "_uncorr_cnt"}, uncorr_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mask;
    logic [3:0] w;
    int         b0, b1;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Directed frames for 4'b1011 (codeword 8'hAA): clean, pos5, pos5+6, pos0.
    send(4'b1011, 8'h00, 8'hAA, mk_dec(4'b1011, 1'b0, 1'b0, 3'd0));
    wait_idle();
    repeat (5) @(negedge clk);
    check("out_data_hold", out_data, 4'b1011);
    send(4'b1011, 8'h20, 8'hAA, mk_dec(4'b1011, 1'b1, 1'b0, 3'd5));
    send(4'b1011, 8'h60, 8'hAA, mk_dec(4'b1101, 1'b0, 1'b1, 3'd3));
    send(4'b1011, 8'h01, 8'hAA, mk_dec(4'b1011, 1'b1, 1'b0, 3'd0));
    wait_idle();

    // Back-to-back words 1..5 must give one unbroken 40-bit run.
    for (int i = 1; i <= 5; i++) send_rand(4'(i), 8'h00);
    wait_idle();
    check("b2b_run", last_run, 40);

    // Hand-driven RX: stray bits, sof without valid, aborted partial, then two frames.
    man_mode = 1'b1;
    repeat (3) drive_rx(1'b1, 1'b1, 1'b0);
    drive_rx(1'b1, 1'b0, 1'b1);
    repeat (7) drive_rx(1'b1, 1'b1, 1'b0);
    drive_rx(1'b1, 1'b1, 1'b1);
    drive_rx(1'b0, 1'b1, 1'b0);
    drive_rx(1'b1, 1'b1, 1'b0);
    rx_frame(model_enc(4'b0110) ^ 8'h08);
    rx_frame(model_enc(4'b1001));
    drive_rx(1'b0, 1'b0, 1'b0);
    wait_idle();
    man_mode = 1'b0;

    // Reset in the middle of a looped-back frame.
    send_rand(4'b1100, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Random traffic with 0, 1 or 2 flipped positions.
    for (int i = 0; i < 40; i++) begin
      w    = 4'($urandom_range(0, 15));
      mask = 8'h00;
      case ($urandom_range(0, 2))
        1: mask[$urandom_range(0, 7)] = 1'b1;
        2: begin
          b0 = $urandom_range(0, 7);
          b1 = (b0 + $urandom_range(1, 7)) % 8;
          mask[b0] = 1'b1;
          mask[b1] = 1'b1;
        end
        default: mask = 8'h00;
      endcase
      send_rand(w, mask);
    end
    wait_idle();

    // Push both counters past their ceiling.
    for (int i = 0; i < 8; i++) send_rand(4'(i), 8'h10);
    for (int i = 0; i < 8; i++) send_rand(4'(i + 8), 8'h82);
    wait_idle();
    check("corr_sat", corr_cnt, CMAX);
    check("uncorr_sat", uncorr_cnt, CMAX);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_secded_link.md
# hamming_secded_link

Parametrised Hamming SEC-DED serial link: one transmit path (encode + serialise) and one receive path (deserialise + decode) on a single clock. It is the successor to the fixed (7,4) encode/decode chain. Code size is set by R, and an overall-parity bit adds double-error detection. Data moves through valid/ready on the parallel side and a framed bit stream on the serial side, and error statistics are kept in saturating counters.

## Interface
Parameters:
- R, 3: Hamming parity bits. K = 2^R-R-1 data bits; N = 2^R bits per frame (positions 0..2^R-1). Legal R: 3..6.
- CW, 16: error-counter width.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  K  word to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  tx accepts word this cycle
- tx_bit  out  1  serial output bit
- tx_valid  out  1  tx_bit valid
- tx_sof  out  1  marks first bit (position 0) of a frame
- rx_bit  in  1  serial input bit
- rx_valid  in  1  rx_bit valid
- rx_sof  in  1  with rx_valid: bit is position 0 of a new frame
- out_data  out  K  decoded word
- out_valid  out  1  one-cycle pulse per decoded frame
- out_corr  out  1  single error corrected
- out_uncorr  out  1  double error detected; data uncorrected
- err_pos  out  R  syndrome (error position 1..N-1; 0 if none or position 0)
- corr_cnt  out  CW  corrected-frame count, saturating
- uncorr_cnt  out  CW  uncorrectable-frame count, saturating

## Operation
- Codeword layout: position p (1..N-1) is a parity bit when p is a power of two; the other positions carry data bits d[0], d[1], … in ascending position order. Each parity bit at 2^j is the XOR of all positions p with bit j of p set. Position 0 holds the XOR of positions 1..N-1, so the whole frame has even parity.
- TX FSM, two states:
  - IDLE: in_ready=1. On in_valid: latch the codeword, go to SHIFT.
  - SHIFT: emit positions 0..N-1, one per cycle, with tx_valid=1; tx_sof=1 on position 0. in_ready=1 only during the position N-1 cycle.
  - If a word is accepted on the position N-1 cycle, SHIFT restarts at position 0 on the next cycle. This gives gapless back-to-back frames. Otherwise the FSM returns to IDLE.
- RX collector:
  - Captures a bit only when rx_valid=1.
  - rx_valid with rx_sof loads position 0 and discards any partial frame.
  - Bits without rx_sof while no frame is open are dropped.
  - rx_sof with rx_valid=0 is ignored.
  - After position N-1 is captured, the frame goes to the decoder and the collector closes.
- Decode: syndrome s = XOR of the indices of all set positions; overall parity q = XOR of all N bits.
  - s=0, q=0: clean.
  - s≠0, q=1: flip position s, out_corr=1.
  - s=0, q=1: position-0 error, out_corr=1, data unchanged.
  - s≠0, q=0: out_uncorr=1, raw data passed through.
  - err_pos=s in all cases.
- Counters: increment on out_valid with the matching flag. They hold at 2^CW-1.

## Timing
- Reset values:
  - in_ready=1
  - tx_bit, tx_valid, tx_sof, out_valid, out_corr, out_uncorr = 0
  - out_data, err_pos, both counters = 0
  - TX in IDLE, RX collector closed
- Reset mid-frame aborts both paths with no partial output.
- TX latency: word accepted at cycle t puts position 0 on tx_bit at t+1. Position N-1 appears at t+N.
- RX latency: last bit captured at cycle t gives out_valid, data, flags and err_pos at t+1, all registered. Counters reflect that frame at t+2.
- out_data, flags and err_pos hold between out_valid pulses.
- No backpressure on out_valid.
- A new frame may start in the cycle after position N-1 is captured.

## Structure
- Package hamming_pkg holds:
  - position-is-parity function
  - data-to-position map
  - encode function (K to N)
  - syndrome function (N to R)
  - overall-parity function
  - all parametrised on R
- One sub-module: hamming_secded_dec. It is combinational: takes N bits, returns corrected data, s, and the corr/uncorr flags. It sits between the RX collector and the output register.
- TX FSM, RX collector and counters live in the top module.

## Test plan
All scenarios use R=3: K=4, N=8.
- Encode: in_data=4'b1011 accepted at t → tx_bit from t+1 is 0,1,0,1,0,1,0,1 (codeword 8'hAA, position 0 first); tx_sof at t+1 only.
- Clean loopback (tx_bit/tx_valid/tx_sof wired to rx) → out_valid one cycle after the eighth bit; out_data=4'b1011, corr=uncorr=0, err_pos=0.
- Position 5 flipped → out_data=4'b1011, out_corr=1, err_pos=5, corr_cnt=1.
- Positions 5 and 6 flipped → out_uncorr=1, err_pos=3, out_data=4'b1101, uncorr_cnt=1.
- Position 0 flipped → out_corr=1, err_pos=0, out_data=4'b1011.
- in_valid held high with words 1..5 → 40 consecutive tx_valid cycles, in_ready high only on the position-7 cycles. Additional checks:
  - rx_sof reasserted mid-frame discards the partial frame; only the restarted frame decodes.
  - rst during a frame returns all outputs to reset values next cycle.
  - Counters forced near 2^CW-1 saturate.
